// File: rtl/serial_link_noc_credit_bridge.sv
// NumChan NoC flit channels multiplexed onto one AXI-Stream link with per-channel credit flow control.
// Optional per-channel statistics counters are built when SERIAL_LINK_NOC_CREDIT_STATS_EN is defined.
module serial_link_noc_credit_bridge #(
  parameter  int unsigned NumChan     = 2,
  parameter  int unsigned FlitWidth   = 64,
  parameter  int unsigned TxFifoDepth = 2,
  parameter  int unsigned RxFifoDepth = 4,
  localparam int unsigned IdxW        = (NumChan > 1) ? $clog2(NumChan) : 1,
  localparam int unsigned CntW        = $clog2(RxFifoDepth + 1),
  localparam int unsigned PayloadW    = FlitWidth + 2 * IdxW + 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChan-1:0]           chan_in_valid_i,
  output logic [NumChan-1:0]           chan_in_ready_o,
  input  logic [NumChan*FlitWidth-1:0] chan_in_data_i,
  output logic [NumChan-1:0]           chan_out_valid_o,
  input  logic [NumChan-1:0]           chan_out_ready_i,
  output logic [NumChan*FlitWidth-1:0] chan_out_data_o,
  output logic                         axis_out_tvalid_o,
  input  logic                         axis_out_tready_i,
  output logic [PayloadW-1:0]          axis_out_tdata_o,
  input  logic                         axis_in_tvalid_i,
  output logic                         axis_in_tready_o,
  input  logic [PayloadW-1:0]          axis_in_tdata_i,
  output logic                         err_overflow_o
`ifdef SERIAL_LINK_NOC_CREDIT_STATS_EN
  ,
  output logic [NumChan*32-1:0]        stat_tx_flits_o,
  output logic [NumChan*32-1:0]        stat_stall_o
`endif
);
  localparam int unsigned TxPtrW = (TxFifoDepth > 1) ? $clog2(TxFifoDepth) : 1;
  localparam int unsigned TxCntW = $clog2(TxFifoDepth + 1);
  localparam int unsigned RxPtrW = (RxFifoDepth > 1) ? $clog2(RxFifoDepth) : 1;
  localparam logic [CntW-1:0] CrdMax = CntW'(RxFifoDepth);

  logic [CntW-1:0]      tx_credit   [NumChan];
  logic [CntW-1:0]      pend_credit [NumChan];
  logic [IdxW-1:0]      rr_ptr;
  logic [NumChan-1:0]   eligible;
  logic                 grant_any;
  logic [IdxW-1:0]      grant_idx;
  logic                 crd_any;
  logic [IdxW-1:0]      crd_sel;
  logic [FlitWidth-1:0] tx_flit;
  logic                 tx_full, tx_accept, tx_enq, tx_deq;
  logic [PayloadW-1:0]  tx_beat;
  logic [PayloadW-1:0]  tx_mem [TxFifoDepth];
  logic [TxPtrW-1:0]    tx_wr, tx_rd;
  logic [TxCntW-1:0]    tx_cnt;
  logic [NumChan-1:0]   flit_take, crd_take, crd_ret;

  logic                 in_crd_vld, in_dat_vld;
  logic [IdxW-1:0]      in_crd_idx, in_dat_idx;
  logic [FlitWidth-1:0] in_flit;
  logic                 rx_fire, rx_drop, rx_hit;
  logic [FlitWidth-1:0] rx_mem [NumChan][RxFifoDepth];
  logic [RxPtrW-1:0]    rx_wr  [NumChan];
  logic [RxPtrW-1:0]    rx_rd  [NumChan];
  logic [CntW-1:0]      rx_cnt [NumChan];
  logic [NumChan-1:0]   rx_push, rx_pop;

  // Two-pass round robin: first eligible at or above the pointer, else lowest eligible overall.
  always_comb begin
    eligible  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    crd_any   = 1'b0;
    crd_sel   = '0;
    for (int unsigned c = 0; c < NumChan; c++)
      eligible[c] = chan_in_valid_i[c] && (tx_credit[c] != '0);
    for (int unsigned c = 0; c < NumChan; c++)
      if (!grant_any && eligible[c] && (IdxW'(c) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(c);
      end
    for (int unsigned c = 0; c < NumChan; c++)
      if (!grant_any && eligible[c]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(c);
      end
    for (int unsigned c = 0; c < NumChan; c++)
      if (!crd_any && (pend_credit[c] != '0)) begin
        crd_any = 1'b1;
        crd_sel = IdxW'(c);
      end
  end

  assign tx_full   = (tx_cnt == TxCntW'(TxFifoDepth));
  assign tx_accept = grant_any && !tx_full;
  assign tx_enq    = !tx_full && (grant_any || crd_any);
  assign tx_deq    = (tx_cnt != '0) && axis_out_tready_i;
  assign tx_beat   = {crd_any, crd_sel, grant_any, grant_idx, tx_flit};

  assign {in_crd_vld, in_crd_idx, in_dat_vld, in_dat_idx, in_flit} = axis_in_tdata_i;
  assign axis_in_tready_o = !rst_i;
  assign rx_fire          = axis_in_tvalid_i && axis_in_tready_o;

  always_comb begin
    chan_in_ready_o = '0;
    tx_flit         = '0;
    flit_take       = '0;
    crd_take        = '0;
    crd_ret         = '0;
    for (int unsigned c = 0; c < NumChan; c++) begin
      chan_in_ready_o[c] = grant_any && (grant_idx == IdxW'(c)) && !tx_full && !rst_i;
      if (grant_any && (grant_idx == IdxW'(c)))
        tx_flit = chan_in_data_i[c*FlitWidth +: FlitWidth];
      flit_take[c] = chan_in_ready_o[c] && chan_in_valid_i[c];
      crd_take[c]  = tx_enq && crd_any && (crd_sel == IdxW'(c));
      crd_ret[c]   = rx_fire && in_crd_vld && (in_crd_idx == IdxW'(c));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      for (int unsigned c = 0; c < NumChan; c++) begin
        tx_credit[c]   <= CrdMax;
        pend_credit[c] <= '0;
      end
    end else begin
      if (tx_accept)
        rr_ptr <= (grant_idx == IdxW'(NumChan - 1)) ? '0 : grant_idx + 1'b1;
      for (int unsigned c = 0; c < NumChan; c++) begin
        if (crd_ret[c] && !flit_take[c]) begin
          assert (tx_credit[c] != CrdMax);
          if (tx_credit[c] != CrdMax) tx_credit[c] <= tx_credit[c] + 1'b1;
        end else if (flit_take[c] && !crd_ret[c]) begin
          tx_credit[c] <= tx_credit[c] - 1'b1;
        end
        if (rx_pop[c] && !crd_take[c]) begin
          if (pend_credit[c] != CrdMax) pend_credit[c] <= pend_credit[c] + 1'b1;
        end else if (crd_take[c] && !rx_pop[c]) begin
          pend_credit[c] <= pend_credit[c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_enq) tx_wr <= (tx_wr == TxPtrW'(TxFifoDepth - 1)) ? '0 : tx_wr + 1'b1;
      if (tx_deq) tx_rd <= (tx_rd == TxPtrW'(TxFifoDepth - 1)) ? '0 : tx_rd + 1'b1;
      if (tx_enq && !tx_deq)      tx_cnt <= tx_cnt + 1'b1;
      else if (tx_deq && !tx_enq) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i)
    if (tx_enq) tx_mem[tx_wr] <= tx_beat;

  assign axis_out_tvalid_o = (tx_cnt != '0);
  assign axis_out_tdata_o  = axis_out_tvalid_o ? tx_mem[tx_rd] : '0;

  always_comb begin
    rx_push = '0;
    rx_pop  = '0;
    rx_hit  = 1'b0;
    rx_drop = 1'b0;
    for (int unsigned c = 0; c < NumChan; c++) begin
      rx_pop[c] = chan_out_valid_o[c] && chan_out_ready_i[c];
      if (in_dat_idx == IdxW'(c)) begin
        rx_hit = 1'b1;
        if (rx_fire && in_dat_vld) begin
          if (rx_cnt[c] == CrdMax) rx_drop = 1'b1;
          else                     rx_push[c] = 1'b1;
        end
      end
    end
    if (rx_fire && in_dat_vld && !rx_hit) rx_drop = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        rx_wr[c]  <= '0;
        rx_rd[c]  <= '0;
        rx_cnt[c] <= '0;
      end
      err_overflow_o <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        if (rx_push[c]) rx_wr[c] <= (rx_wr[c] == RxPtrW'(RxFifoDepth - 1)) ? '0 : rx_wr[c] + 1'b1;
        if (rx_pop[c])  rx_rd[c] <= (rx_rd[c] == RxPtrW'(RxFifoDepth - 1)) ? '0 : rx_rd[c] + 1'b1;
        if (rx_push[c] && !rx_pop[c])      rx_cnt[c] <= rx_cnt[c] + 1'b1;
        else if (rx_pop[c] && !rx_push[c]) rx_cnt[c] <= rx_cnt[c] - 1'b1;
      end
      if (rx_drop) err_overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i)
    for (int unsigned c = 0; c < NumChan; c++)
      if (rx_push[c]) rx_mem[c][rx_wr[c]] <= in_flit;

  always_comb begin
    chan_out_valid_o = '0;
    chan_out_data_o  = '0;
    for (int unsigned c = 0; c < NumChan; c++) begin
      chan_out_valid_o[c] = (rx_cnt[c] != '0);
      if (chan_out_valid_o[c]) chan_out_data_o[c*FlitWidth +: FlitWidth] = rx_mem[c][rx_rd[c]];
    end
  end

`ifdef SERIAL_LINK_NOC_CREDIT_STATS_EN
  logic [31:0] stat_tx [NumChan];
  logic [31:0] stat_st [NumChan];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        stat_tx[c] <= '0;
        stat_st[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        if (flit_take[c]) stat_tx[c] <= stat_tx[c] + 1'b1;
        if (chan_in_valid_i[c] && (tx_credit[c] == '0)) stat_st[c] <= stat_st[c] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_tx_flits_o = '0;
    stat_stall_o    = '0;
    for (int unsigned c = 0; c < NumChan; c++) begin
      stat_tx_flits_o[c*32 +: 32] = stat_tx[c];
      stat_stall_o[c*32 +: 32]    = stat_st[c];
    end
  end
`endif

endmodule

// File: tb/tb_serial_link_noc_credit_bridge.sv
// Scoreboard bench for serial_link_noc_credit_bridge: loopback traffic, back-pressure, credit return,
// overflow and mid-stall reset scenarios with hand-computed expected flits and beats.
module tb_serial_link_noc_credit_bridge;
  localparam int unsigned NumChan     = 2;
  localparam int unsigned FlitWidth   = 64;
  localparam int unsigned TxFifoDepth = 2;
  localparam int unsigned RxFifoDepth = 4;
  localparam int unsigned PayloadW    = FlitWidth + 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           in_valid, in_ready, out_valid, out_ready;
  logic [127:0]         in_data, out_data;
  logic                 tx_tvalid, tx_tready, rx_tvalid, rx_tready;
  logic [PayloadW-1:0]  tx_tdata, rx_tdata;
  logic                 err;
  logic                 lb, inj_valid, inj_tready;
  logic [PayloadW-1:0]  inj_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int grant_log[$];
  int sent0, sent1;

  assign rx_tvalid = lb ? tx_tvalid : inj_valid;
  assign rx_tdata  = lb ? tx_tdata  : inj_data;
  assign tx_tready = lb ? rx_tready : inj_tready;

  serial_link_noc_credit_bridge #(
    .NumChan(NumChan), .FlitWidth(FlitWidth), .TxFifoDepth(TxFifoDepth), .RxFifoDepth(RxFifoDepth)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .chan_in_valid_i(in_valid), .chan_in_ready_o(in_ready), .chan_in_data_i(in_data),
    .chan_out_valid_o(out_valid), .chan_out_ready_i(out_ready), .chan_out_data_o(out_data),
    .axis_out_tvalid_o(tx_tvalid), .axis_out_tready_i(tx_tready), .axis_out_tdata_o(tx_tdata),
    .axis_in_tvalid_i(rx_tvalid), .axis_in_tready_o(rx_tready), .axis_in_tdata_i(rx_tdata),
    .err_overflow_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int c, input int k);
    return {16'hC0DE, 8'(c), 8'h00, 32'(k)};
  endfunction

  function automatic logic [PayloadW-1:0] beat(input logic cv, input logic ci, input logic dv,
                                               input logic di, input logic [63:0] f);
    return {cv, ci, dv, di, f};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    inj_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Issues flits on both channels; expected flits are queued at the cycle of the handshake.
  task automatic drive(input int n0, input int n1, input int base0, input int base1, input int budget);
    int cyc = 0;
    sent0 = 0;
    sent1 = 0;
    while ((sent0 < n0 || sent1 < n1) && cyc < budget) begin
      in_valid[0]     = (sent0 < n0);
      in_data[63:0]   = mk(0, base0 + sent0);
      in_valid[1]     = (sent1 < n1);
      in_data[127:64] = mk(1, base1 + sent1);
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) begin
        exp_q0.push_back(in_data[63:0]);
        grant_log.push_back(0);
        sent0++;
      end
      if (in_valid[1] && in_ready[1]) begin
        exp_q1.push_back(in_data[127:64]);
        grant_log.push_back(1);
        sent1++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = '0;
  endtask

  initial begin : monitor
    logic [63:0] got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_tvalid) chk("beat_nonempty", 128'({tx_tdata[PayloadW-1], tx_tdata[FlitWidth+1]} != 2'b00), 128'd1);
        if (out_valid[0] && out_ready[0]) begin
          got = out_data[63:0];
          if (exp_q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ch0_extra: got %0h expected none", got);
          end else chk("ch0_flit", got, exp_q0.pop_front());
        end
        if (out_valid[1] && out_ready[1]) begin
          got = out_data[127:64];
          if (exp_q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ch1_extra: got %0h expected none", got);
          end else chk("ch1_flit", got, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [PayloadW-1:0] held;
    lb         = 1'b1;
    inj_valid  = 1'b0;
    inj_data   = '0;
    inj_tready = 1'b1;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = 2'b11;
    rst        = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rx_tready", rx_tready, 0);
    chk("rst_err", err, 0);
    chk("rst_credit0", dut.tx_credit[0], 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk("rx_tready_live", rx_tready, 1);

    // Loopback, both channels streaming, sinks always ready.
    grant_log.delete();
    drive(10, 10, 0, 100, 100);
    chk("s1_sent0", sent0, 10);
    chk("s1_sent1", sent1, 10);
    for (int i = 0; i < 20; i++)
      chk("s1_rr_order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
    tick(12);
    chk("s1_q0_empty", exp_q0.size(), 0);
    chk("s1_q1_empty", exp_q1.size(), 0);
    chk("s1_err", err, 0);

    // Channel 0 sink stalled: only its credit worth of flits may cross.
    do_reset();
    out_ready = 2'b10;
    drive(10, 10, 0, 100, 60);
    chk("s2_sent0", sent0, 4);
    chk("s2_sent1", sent1, 10);
    in_valid[0]   = 1'b1;
    in_data[63:0] = mk(0, 4);
    @(negedge clk);
    chk("s2_ready0_blocked", in_ready[0], 0);
    chk("s2_credit0", dut.tx_credit[0], 0);
    chk("s2_out_valid0", out_valid[0], 1);
    @(posedge clk);
    #1;
    in_valid = '0;

    // Release sink 0: credits return and the rest of channel 0 crosses.
    out_ready = 2'b11;
    drive(6, 0, 4, 0, 100);
    chk("s3_sent0", sent0, 6);
    tick(15);
    chk("s3_credit0", dut.tx_credit[0], 4);
    chk("s3_credit1", dut.tx_credit[1], 4);
    chk("s3_q0_empty", exp_q0.size(), 0);
    chk("s3_q1_empty", exp_q1.size(), 0);
    chk("s3_err", err, 0);

    // Credit return for channel 1 coincides with a channel 1 accept.
    do_reset();
    lb              = 1'b0;
    inj_tready      = 1'b1;
    in_valid[1]     = 1'b1;
    in_data[127:64] = mk(1, 50);
    inj_valid       = 1'b1;
    inj_data        = beat(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("s4_ready1", in_ready[1], 1);
    @(posedge clk);
    #1;
    in_valid  = '0;
    inj_valid = 1'b0;
    chk("s4_credit1", dut.tx_credit[1], 4);
    chk("s4_credit0", dut.tx_credit[0], 4);
    chk("s4_tvalid", tx_tvalid, 1);
    chk("s4_tdata", tx_tdata, beat(1'b0, 1'b0, 1'b1, 1'b1, mk(1, 50)));
    tick(2);

    // Five data beats into a stalled channel 0 FIFO of depth 4.
    do_reset();
    lb        = 1'b0;
    out_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      inj_valid = 1'b1;
      inj_data  = beat(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 200 + k));
      if (k < 4) exp_q0.push_back(mk(0, 200 + k));
      if (k == 4) chk("s5_err_before", err, 0);
      tick(1);
    end
    inj_valid = 1'b0;
    chk("s5_err_set", err, 1);
    chk("s5_out_valid0", out_valid[0], 1);
    chk("s5_head", out_data[63:0], mk(0, 200));
    out_ready = 2'b11;
    tick(10);
    chk("s5_err_sticky", err, 1);
    chk("s5_q0_empty", exp_q0.size(), 0);
    do_reset();
    chk("s5_err_cleared", err, 0);

    // Output stall holds the beat; reset mid-stall clears everything.
    lb            = 1'b0;
    inj_tready    = 1'b0;
    in_valid[0]   = 1'b1;
    in_data[63:0] = mk(0, 300);
    @(negedge clk);
    chk("s6_ready0", in_ready[0], 1);
    @(posedge clk);
    #1;
    in_valid = '0;
    held     = beat(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 300));
    for (int i = 0; i < 3; i++) begin
      chk("s6_stall_tvalid", tx_tvalid, 1);
      chk("s6_stall_tdata", tx_tdata, held);
      tick(1);
    end
    #2;
    rst      = 1'b1;
    in_valid = 2'b11;
    @(negedge clk);
    chk("s6_rst_tvalid", tx_tvalid, 0);
    chk("s6_rst_out_valid", out_valid, 0);
    chk("s6_rst_in_ready", in_ready, 0);
    chk("s6_rst_credit0", dut.tx_credit[0], 4);
    @(posedge clk);
    #1;
    in_valid   = '0;
    rst        = 1'b0;
    inj_tready = 1'b1;
    tick(2);
    chk("s6_post_credit0", dut.tx_credit[0], 4);
    chk("s6_post_rx_tready", rx_tready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
